// File: rtl/qlm_acc_pkg.sv
// Shared types and default widths for the QLM frame accumulator.
package qlm_acc_pkg;

  localparam int P_W   = 32;
  localparam int ACC_W = 40;
  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

endpackage

// File: rtl/qlm_acc_frame_add.sv
// Zero-extending accumulator adder with carry-out.
// ACC_SAT_EN clamps the sum to all-ones on carry.
module qlm_acc_add
  import qlm_acc_pkg::*;
#(
  parameter int PW = P_W,
  parameter int AW = ACC_W
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] p,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW:0] full;

  always_comb begin
    full  = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, p};
    carry = full[AW];
`ifdef ACC_SAT_EN
    sum   = carry ? {AW{1'b1}} : full[AW-1:0];
`else
    sum   = full[AW-1:0];
`endif
  end

endmodule

// File: rtl/qlm_acc_frame.sv
// Frame accumulator for QLM multiplier products.
// Build option ACC_SAT_EN selects saturating accumulation.
module qlm_acc_frame
  import qlm_acc_pkg::*;
#(
  parameter int P_W   = qlm_acc_pkg::P_W,
  parameter int ACC_W = qlm_acc_pkg::ACC_W,
  parameter int LEN_W = qlm_acc_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [P_W-1:0]   p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             overflow
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum;
  logic               carry;

  qlm_acc_add #(
    .PW(P_W),
    .AW(ACC_W)
  ) u_add (
    .acc  (acc_q),
    .p    (p_in),
    .sum  (sum),
    .carry(carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = frame_len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (frame_len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (p_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign p_ready   = (state_q == ACCUM);
  assign acc_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/qlm_acc_frame.md
# qlm_acc_frame

Frame accumulator directly downstream of the registered QLM 16x16 approximate multiplier stage. It sums a programmed number of unsigned 32-bit products into a wide accumulator and presents the frame sum through a valid/ready handshake. It provides dot-product and approximation-error-sum evaluation of the multiplier without a software readback per product.

## Interface
- P_W, 32, product width; matches the multiplier output.
- ACC_W, 40, accumulator width; must be greater than or equal to P_W.
- LEN_W, 8, frame-length counter width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- frame_len  in  LEN_W  number of products in the frame; sampled with start.
- p_in  in  P_W  product from the multiplier stage.
- p_valid  in  1  p_in valid.
- p_ready  out  1  accumulator accepts p_in.
- acc_out  out  ACC_W  frame sum.
- acc_valid  out  1  acc_out holds a final frame sum.
- acc_ready  in  1  consumer accepts acc_out.
- busy  out  1  high whenever the state is not IDLE.
- overflow  out  1  sticky per frame; set when any addition carries out of ACC_W.

## Operation
- Clock is one clock named clk. Reset is asynchronous and active-low, named rst_n.
- All arithmetic is unsigned. p_in is zero-extended to ACC_W before each addition.
- FSM states are IDLE, ACCUM and DONE.
- IDLE:
  - p_ready=0, acc_valid=0.
  - When start=1: latch frame_len into the remaining-count register, clear acc_out and clear overflow.
  - If frame_len!=0, go to ACCUM. If frame_len==0, go directly to DONE with acc_out=0.
- ACCUM:
  - p_ready=1.
  - A beat is p_valid && p_ready. On each beat: acc_out += p_in and decrement the count.
  - The beat that makes the count 0 moves the FSM to DONE.
  - Cycles where p_valid=0 leave all state unchanged.
- DONE:
  - p_ready=0, acc_valid=1.
  - On acc_valid && acc_ready, go to IDLE.
- start is ignored outside IDLE, including a start coincident with the DONE handshake.
- frame_len changes after the start cycle have no effect on the running frame.
- Overflow: a carry out of bit ACC_W-1 sets overflow. The accumulator result after a carry depends on ACC_SAT_EN (see Configuration).

## Timing
- Reset values: p_ready=0, acc_valid=0, acc_out=0, busy=0, overflow=0. The FSM resets to IDLE and the count to 0.
- Reset asserted mid-frame aborts the frame immediately. No partial result is output.
- start sampled at cycle t: busy=1 and p_ready=1 from t+1. For frame_len=0, acc_valid=1 from t+1.
- Last beat at cycle k: acc_valid=1 and the final acc_out are visible at k+1. p_ready=0 from k+1.
- While acc_valid && !acc_ready: acc_out, overflow and acc_valid are held stable.
- Handshake at cycle d: acc_valid=0 and busy=0 from d+1. A start at d+1 is accepted.
- Minimum frame period is frame_len + 2 cycles.
- Throughput in ACCUM is one product per cycle; there are no bubbles.
- The multiplier stage has one-cycle registered output. The producer delays its operand-valid by one cycle to form p_valid.

## Configuration
- ACC_SAT_EN defined:
  - On carry-out, acc_out clamps to all-ones.
  - It stays all-ones for the rest of the frame.
  - overflow is set.
- ACC_SAT_EN undefined:
  - acc_out wraps modulo 2^ACC_W.
  - overflow is still set.

## Structure
- Package qlm_acc_pkg holds:
  - the state enum (IDLE/ACCUM/DONE);
  - default width constants P_W, ACC_W and LEN_W.
- One sub-module, qlm_acc_add: a zero-extending ACC_W adder producing sum and carry.
  - It contains the ACC_SAT_EN clamp.
  - It keeps the macro out of the FSM.

## Test plan
- frame_len=4, p_in=1,2,3,4 on consecutive cycles, acc_ready=1:
  - acc_valid is high exactly one cycle after the 4th beat;
  - acc_out=10, overflow=0.
- Same frame with p_valid gaps of 3 cycles between beats and acc_ready=0 for 5 cycles:
  - acc_out=10 is held stable;
  - p_ready=0 throughout DONE.
- ACC_W=36, frame_len=17, all p_in=0xFFFFFFFF:
  - without ACC_SAT_EN: acc_out=0x0FFFFFFEF, overflow=1;
  - with ACC_SAT_EN: acc_out=0xFFFFFFFFF, overflow=1.
- frame_len=0 with start at t:
  - acc_valid=1 and acc_out=0 at t+1;
  - no beats are accepted.
- rst_n low for one cycle after 2 of 4 beats:
  - all outputs are 0 immediately;
  - a new frame of 5,5 gives acc_out=10.
- start pulses during ACCUM and DONE:
  - they are ignored, and frame_len is unchanged.
  - A start in the cycle after the DONE handshake begins a new frame.
